// File: rtl/speaker_decide.sv
`default_nettype none
// ============================================================================
//  Module      : speaker_decide
//  Description : Speaker decision stage behind the Euclidean distance engine.
//                Collects one distortion per speaker codebook, tracks the
//                best and second-best distortion and the winning id, then
//                applies an absolute threshold and a confidence-margin test.
//                The result is presented on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module speaker_decide #(
    parameter int N_SPK       = 4,
    parameter int DIST_WIDTH  = 30,
    parameter int THR_WIDTH   = 16,
    parameter int FRAME_WIDTH = 9,
    parameter int MARGIN_MIN  = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [FRAME_WIDTH-1:0] frame_num,
    input  logic [THR_WIDTH-1:0]   thr_per_frame,
    input  logic                   dist_valid,
    input  logic [DIST_WIDTH-1:0]  dist_data,
    output logic                   dist_ready,
    output logic                   busy,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [3:0]             dec_id,
    output logic [DIST_WIDTH-1:0]  dec_dist,
    output logic [DIST_WIDTH-1:0]  dec_margin,
    output logic                   dec_reject,
    output logic                   err_overrun
);

    localparam int         c_PROD_W = THR_WIDTH + FRAME_WIDTH;
    localparam int         c_CMP_W  = (DIST_WIDTH > c_PROD_W) ? DIST_WIDTH : c_PROD_W;
    localparam logic [3:0] c_LAST   = 4'(N_SPK - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_SCALE   = 3'd2,
        S_DECIDE  = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_in_valid;
    logic [DIST_WIDTH-1:0]   r_in_data;
    logic [FRAME_WIDTH-1:0]  r_frame_num;
    logic [THR_WIDTH-1:0]    r_thr;
    logic [3:0]              r_cnt;
    logic [3:0]              r_id;
    logic [DIST_WIDTH-1:0]   r_min1;
    logic [DIST_WIDTH-1:0]   r_min2;
    logic [c_PROD_W-1:0]     r_thr_scaled;

    logic [DIST_WIDTH-1:0]   w_margin;
    logic [c_CMP_W-1:0]      w_min1_ext;
    logic [c_CMP_W-1:0]      w_thr_ext;
    logic                    w_reject;

    // With a single codebook there is no runner-up, so the margin is
    // reported as fully confident rather than as all-ones minus the winner.
    generate
        if (N_SPK == 1) begin : g_single
            assign w_margin = '1;
        end else begin : g_multi
            assign w_margin = r_min2 - r_min1;
        end
    endgenerate

    assign w_min1_ext = c_CMP_W'(r_min1);
    assign w_thr_ext  = c_CMP_W'(r_thr_scaled);
    assign w_reject   = (w_min1_ext > w_thr_ext)
                      | (w_margin < DIST_WIDTH'(MARGIN_MIN))
                      | (r_frame_num == '0);

    assign busy       = (r_state != S_IDLE);
    assign dist_ready = (r_state == S_COLLECT);

    // Register the incoming strobe: the distortion arrives straight off the
    // engine's accumulator, so the compare chain starts from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_valid <= 1'b0;
            r_in_data  <= '0;
        end else begin
            r_in_valid <= dist_valid;
            r_in_data  <= dist_data;
        end
    end

    // Round sequencer: collect, scale threshold, decide, hold for handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_frame_num  <= '0;
            r_thr        <= '0;
            r_cnt        <= '0;
            r_id         <= '0;
            r_min1       <= '1;
            r_min2       <= '1;
            r_thr_scaled <= '0;
            dec_valid    <= 1'b0;
            dec_id       <= '0;
            dec_dist     <= '0;
            dec_margin   <= '0;
            dec_reject   <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_frame_num <= frame_num;
                        r_thr       <= thr_per_frame;
                        r_cnt       <= '0;
                        r_id        <= '0;
                        r_min1      <= '1;
                        r_min2      <= '1;
                        err_overrun <= 1'b0;
                        r_state     <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (r_in_valid) begin
                        // Strict compares: on a tie the earlier speaker keeps the win.
                        if (r_in_data < r_min1) begin
                            r_min2 <= r_min1;
                            r_min1 <= r_in_data;
                            r_id   <= r_cnt;
                        end else if (r_in_data < r_min2) begin
                            r_min2 <= r_in_data;
                        end
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == c_LAST) begin
                            r_state <= S_SCALE;
                        end
                    end
                end
                S_SCALE: begin
                    r_thr_scaled <= c_PROD_W'(r_thr) * c_PROD_W'(r_frame_num);
                    r_state      <= S_DECIDE;
                end
                S_DECIDE: begin
                    dec_id     <= r_id;
                    dec_dist   <= r_min1;
                    dec_margin <= w_margin;
                    dec_reject <= w_reject;
                    dec_valid  <= 1'b1;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (dec_valid && dec_ready) begin
                        dec_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // A strobe arriving while not collecting is dropped but flagged;
            // placed last so it also wins over the clear on start.
            if (r_in_valid && (r_state != S_COLLECT)) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
